// File: rtl/vcap_pkg.sv
// Shared constants, FSM encoding and pixel payload type for the video capture front end.
package vcap_pkg;

    localparam int unsigned H_ACTIVE = 720;
    localparam int unsigned V_ACTIVE = 240;
    localparam int unsigned H_DECIM  = 4;
    localparam int unsigned V_DECIM  = 2;
    localparam int unsigned OUT_W    = H_ACTIVE / H_DECIM;
    localparam int unsigned OUT_H    = V_ACTIVE / V_DECIM;
    localparam int unsigned IDX_W    = 15;

    localparam logic [15:0] BANK1_BASE = 16'h8000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ARM  = 1'b1
    } vcap_state_e;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } ycc_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop delay line with rise/fall detection; edges are suppressed until both
// flops hold real samples so a level already high at reset release is not an edge.
module sync_edge_det (
    input  logic clk_llc2,
    input  logic resetx,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic       s1;
    logic       s2;
    logic [1:0] seeded;

    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            seeded <= 2'b00;
        end else begin
            s1     <= din;
            s2     <= s1;
            seeded <= {seeded[0], 1'b1};
        end
    end

    assign lvl  = s1;
    assign rise = seeded[1] & s1 & ~s2;
    assign fall = seeded[1] & ~s1 & s2;

endmodule

// File: rtl/video_capture_timing.sv
// Odd-field capture front end: registers the decoder port, decimates active video and
// emits {Y,Cb,Cr} triples with ping-pong frame-RAM word addresses.
module video_capture_timing
    import vcap_pkg::*;
#(
    parameter int unsigned H_ACT = H_ACTIVE,
    parameter int unsigned V_ACT = V_ACTIVE,
    parameter int unsigned H_DEC = H_DECIM,
    parameter int unsigned V_DEC = V_DECIM
) (
    input  logic        clk_llc2,
    input  logic        resetx,
    input  logic        vref,
    input  logic        href,
    input  logic        odd,
    input  logic [15:0] vpo,
    output logic        pix_valid,
    output logic [7:0]  pix_y,
    output logic [7:0]  pix_cb,
    output logic [7:0]  pix_cr,
    output logic [15:0] pix_addr,
    output logic        bank,
    output logic        frame_done,
    output logic        field_err
);

    localparam int unsigned PX_W    = $clog2(H_ACT + 1);
    localparam int unsigned LN_W    = $clog2(V_ACT + 2);
    localparam int unsigned IDX_MAX = (H_ACT / H_DEC) * (V_ACT / V_DEC) - 1;

    vcap_state_e      state_q, state_n;
    logic [15:0]      vpo_r, vpo_d;
    logic             odd_r;
    logic             vref_lvl, vref_rise, vref_fall;
    logic             href_lvl, href_rise, href_fall, href_d;
    logic [PX_W-1:0]  px_cnt, px_phase;
    logic [LN_W-1:0]  line_cnt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       y_hold, cb_hold;
    ycc_t             pix_q;
    logic             arm_enter, field_end, field_ok, line_kept, pix_act, latch_even, emit;

    sync_edge_det u_vref_det (
        .clk_llc2 (clk_llc2),
        .resetx   (resetx),
        .din      (vref),
        .lvl      (vref_lvl),
        .rise     (vref_rise),
        .fall     (vref_fall)
    );

    sync_edge_det u_href_det (
        .clk_llc2 (clk_llc2),
        .resetx   (resetx),
        .din      (href),
        .lvl      (href_lvl),
        .rise     (href_rise),
        .fall     (href_fall)
    );

    // Pixel data is processed one stage behind the edge detectors, aligned with href_d.
    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) begin
            vpo_r <= '0;
            vpo_d <= '0;
            odd_r <= 1'b0;
        end else begin
            vpo_r <= vpo;
            vpo_d <= vpo_r;
            odd_r <= odd;
        end
    end

    // Delayed href level recovered from the detector outputs.
    assign href_d = (href_lvl & ~href_rise) | href_fall;

    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) state_q <= ST_IDLE;
        else         state_q <= state_n;
    end

    always_comb begin
        state_n   = state_q;
        arm_enter = 1'b0;
        field_end = 1'b0;
        unique case (state_q)
            ST_IDLE: if (vref_rise && odd_r) begin
                state_n   = ST_ARM;
                arm_enter = 1'b1;
            end
            ST_ARM: if (vref_fall) begin
                state_n   = ST_IDLE;
                field_end = 1'b1;
            end
        endcase
        px_phase   = px_cnt % PX_W'(H_DEC);
        field_ok   = (line_cnt == LN_W'(V_ACT));
        line_kept  = ((line_cnt % LN_W'(V_DEC)) == '0) && (line_cnt < LN_W'(V_ACT));
        // vref_lvl drops on the field-end edge, so a coinciding emit is suppressed.
        pix_act    = (state_q == ST_ARM) && vref_lvl && href_d && line_kept
                     && (px_cnt < PX_W'(H_ACT));
        latch_even = pix_act && (px_phase == '0);
        emit       = pix_act && (px_phase == PX_W'(1));
    end

    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) begin
            px_cnt   <= '0;
            line_cnt <= '0;
            idx      <= '0;
            y_hold   <= '0;
            cb_hold  <= '0;
        end else if (arm_enter) begin
            px_cnt   <= '0;
            line_cnt <= '0;
            idx      <= '0;
        end else if (state_q == ST_ARM) begin
            if (href_rise)
                px_cnt <= '0;
            else if (href_d && (px_cnt < PX_W'(H_ACT)))
                px_cnt <= px_cnt + PX_W'(1);
            if (href_fall && (line_cnt < LN_W'(V_ACT + 1)))
                line_cnt <= line_cnt + LN_W'(1);
            if (emit && (idx < IDX_W'(IDX_MAX)))
                idx <= idx + IDX_W'(1);
            if (latch_even) begin
                y_hold  <= vpo_d[15:8];
                cb_hold <= vpo_d[7:0];
            end
        end
    end

    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) begin
            pix_valid  <= 1'b0;
            pix_q      <= '0;
            pix_addr   <= '0;
            bank       <= 1'b0;
            frame_done <= 1'b0;
            field_err  <= 1'b0;
        end else begin
            pix_valid  <= emit;
            frame_done <= field_end && field_ok;
            field_err  <= field_end && !field_ok;
            if (emit) begin
                pix_q    <= '{y: y_hold, cb: cb_hold, cr: vpo_d[7:0]};
                pix_addr <= (bank ? BANK1_BASE : 16'h0000) | {1'b0, idx};
            end
            if (field_end && field_ok)
                bank <= ~bank;
        end
    end

    assign pix_y  = pix_q.y;
    assign pix_cb = pix_q.cb;
    assign pix_cr = pix_q.cr;

endmodule

// File: tb/tb_video_capture_timing.sv
// Scoreboard bench for video_capture_timing on a reduced 40x12 field (10x6 kept pixels).
module tb_video_capture_timing;

    localparam int TH     = 40;
    localparam int TV     = 12;
    localparam int THD    = 4;
    localparam int TVD    = 2;
    localparam int TN     = (TH / THD) * (TV / TVD);
    localparam int HBLANK = 6;

    logic        clk_llc2 = 1'b0;
    logic        resetx   = 1'b0;
    logic        vref     = 1'b0;
    logic        href     = 1'b0;
    logic        odd      = 1'b0;
    logic [15:0] vpo      = '0;
    logic        pix_valid;
    logic [7:0]  pix_y, pix_cb, pix_cr;
    logic [15:0] pix_addr;
    logic        bank, frame_done, field_err;

    video_capture_timing #(
        .H_ACT (TH),
        .V_ACT (TV),
        .H_DEC (THD),
        .V_DEC (TVD)
    ) dut (
        .clk_llc2   (clk_llc2),
        .resetx     (resetx),
        .vref       (vref),
        .href       (href),
        .odd        (odd),
        .vpo        (vpo),
        .pix_valid  (pix_valid),
        .pix_y      (pix_y),
        .pix_cb     (pix_cb),
        .pix_cr     (pix_cr),
        .pix_addr   (pix_addr),
        .bank       (bank),
        .frame_done (frame_done),
        .field_err  (field_err)
    );

    always #5 clk_llc2 = ~clk_llc2;

    typedef struct packed {
        logic [7:0]  y;
        logic [7:0]  cb;
        logic [7:0]  cr;
        logic [15:0] addr;
    } exp_pix_t;

    typedef struct packed {
        logic done;
        logic bank_after;
    } exp_evt_t;

    exp_pix_t    pix_q[$];
    exp_evt_t    evt_q[$];
    logic [15:0] addr_log[$];
    exp_pix_t    mon_pix;
    exp_evt_t    mon_evt;
    int          checks    = 0;
    int          errors    = 0;
    int          exp_idx   = 0;
    logic        exp_bank  = 1'b0;
    bit          armed     = 1'b0;
    int          long_ln   = -1;
    int          long_len  = 0;
    int          short_ln  = -1;
    int          short_len = 0;

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or a field pulse.
    always @(negedge clk_llc2) begin
        if (resetx) begin
            if (pix_valid) begin
                addr_log.push_back(pix_addr);
                if (pix_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pix: got addr %0h y %0h, want no strobe", pix_addr, pix_y);
                end else begin
                    mon_pix = pix_q.pop_front();
                    check("pix_ycc", {24'h0, pix_y, pix_cb, pix_cr}, {24'h0, mon_pix.y, mon_pix.cb, mon_pix.cr});
                    check("pix_addr", {32'h0, pix_addr}, {32'h0, mon_pix.addr});
                end
            end
            if (frame_done || field_err) begin
                if (evt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_evt: got done=%0b err=%0b, want none", frame_done, field_err);
                end else begin
                    mon_evt = evt_q.pop_front();
                    check("evt_kind", {46'h0, frame_done, field_err}, {46'h0, mon_evt.done, ~mon_evt.done});
                    check("evt_bank", {47'h0, bank}, {47'h0, mon_evt.bank_after});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk_llc2);
        #2;
    endtask

    function automatic logic [7:0] ypix(input int ln, input int px);
        return 8'(px + 7 * ln);
    endfunction

    function automatic int line_len(input int ln);
        if (ln == long_ln)  return long_len;
        if (ln == short_ln) return short_len;
        return TH;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, {47'h0, pix_valid}, 48'h0);
        check({tag, "_y"},     {40'h0, pix_y}, 48'h0);
        check({tag, "_cb"},    {40'h0, pix_cb}, 48'h0);
        check({tag, "_cr"},    {40'h0, pix_cr}, 48'h0);
        check({tag, "_addr"},  {32'h0, pix_addr}, 48'h0);
        check({tag, "_bank"},  {47'h0, bank}, 48'h0);
        check({tag, "_done"},  {47'h0, frame_done}, 48'h0);
        check({tag, "_err"},   {47'h0, field_err}, 48'h0);
    endtask

    task automatic end_field(input int lines);
        exp_evt_t ev;
        if (armed) begin
            if (lines == TV) exp_bank = ~exp_bank;
            ev.done       = (lines == TV);
            ev.bank_after = exp_bank;
            evt_q.push_back(ev);
        end
        armed = 1'b0;
    endtask

    task automatic pulse_reset();
        resetx = 1'b0;
        #1;
        check_outputs_zero("midrst");
        pix_q.delete();
        evt_q.delete();
        armed    = 1'b0;
        exp_bank = 1'b0;
        exp_idx  = 0;
        cyc();
        cyc();
        resetx = 1'b1;
    endtask

    task automatic drive_line(input int ln, input int n_px, input int vdrop_px, input int rst_px);
        exp_pix_t e;
        for (int px = 0; px < n_px; px++) begin
            if (px == vdrop_px) begin
                vref = 1'b0;
                end_field(ln);
            end
            if (px == rst_px) pulse_reset();
            href = 1'b1;
            vpo  = {ypix(ln, px), (px % 2 == 1) ? 8'(8'hC0 + px) : 8'(8'h40 + px)};
            if (armed && (ln % TVD == 0) && (ln < TV) && (px % THD == 1) && (px < TH)
                && (vdrop_px < 0 || px + 1 < vdrop_px)) begin
                e.y    = ypix(ln, px - 1);
                e.cb   = 8'(8'h40 + px - 1);
                e.cr   = 8'(8'hC0 + px);
                e.addr = {exp_bank, 15'(exp_idx)};
                pix_q.push_back(e);
                if (exp_idx < TN - 1) exp_idx++;
            end
            cyc();
        end
        href = 1'b0;
        vpo  = '0;
        repeat (HBLANK) cyc();
    endtask

    task automatic drive_field(input logic od, input int n_lines, input int vdrop_ln,
                               input int vdrop_px, input int rst_ln, input int rst_px);
        addr_log.delete();
        odd  = od;
        vref = 1'b1;
        if (od) begin
            armed   = 1'b1;
            exp_idx = 0;
        end
        repeat (4) cyc();
        for (int ln = 0; ln < n_lines; ln++) begin
            drive_line(ln, line_len(ln), (ln == vdrop_ln) ? vdrop_px : -1,
                       (ln == rst_ln) ? rst_px : -1);
            if (!vref) break;
        end
        if (vref) begin
            vref = 1'b0;
            end_field(n_lines);
        end
        repeat (10) cyc();
    endtask

    task automatic check_field(input string tag, input int nv, input logic [15:0] fa,
                               input logic [15:0] la, input logic b);
        check({tag, "_count"}, 48'(addr_log.size()), 48'(nv));
        if (nv > 0 && addr_log.size() > 0) begin
            check({tag, "_first"}, {32'h0, addr_log[0]}, {32'h0, fa});
            check({tag, "_last"},  {32'h0, addr_log[addr_log.size() - 1]}, {32'h0, la});
        end
        check({tag, "_bank"},     {47'h0, bank}, {47'h0, b});
        check({tag, "_pix_left"}, 48'(pix_q.size()), 48'h0);
        check({tag, "_evt_left"}, 48'(evt_q.size()), 48'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk_llc2);
        #2;
        check_outputs_zero("reset");
        resetx = 1'b1;
        repeat (4) cyc();

        drive_field(1'b1, TV, -1, -1, -1, -1);
        check_field("t1", 60, 16'h0000, 16'h003B, 1'b1);

        drive_field(1'b0, TV, -1, -1, -1, -1);
        check_field("t2_even", 0, 16'h0000, 16'h0000, 1'b1);
        drive_field(1'b1, TV, -1, -1, -1, -1);
        check_field("t2", 60, 16'h8000, 16'h803B, 1'b0);

        drive_field(1'b1, TV - 2, -1, -1, -1, -1);
        check_field("t3", 50, 16'h0000, 16'h0031, 1'b0);

        long_ln   = 2;
        long_len  = TH + 2;
        short_ln  = 4;
        short_len = TH / 2 + 1;
        drive_field(1'b1, TV, -1, -1, -1, -1);
        check_field("t4", 55, 16'h0000, 16'h0036, 1'b1);
        if (addr_log.size() > 25)
            check("t4_row3_start", {32'h0, addr_log[25]}, 48'h0019);
        long_ln  = -1;
        short_ln = -1;

        drive_field(1'b1, TV, -1, -1, 5, 10);
        check_field("t5_abort", 30, 16'h8000, 16'h801D, 1'b0);
        drive_field(1'b1, TV, -1, -1, -1, -1);
        check_field("t5_next", 60, 16'h0000, 16'h003B, 1'b1);

        drive_field(1'b1, TV, 10, 10, -1, -1);
        check_field("t6", 52, 16'h8000, 16'h8033, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
